// File: rtl/riscv_lsu_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
// Request side is registered by the LSU; the memory answers with a read word and a ready strobe.
interface riscv_lsu_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  modport master (
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    input  mem_rd_i, mem_ready_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    output mem_rd_i, mem_ready_i
  );
endinterface

// File: rtl/riscv_lsu.sv
// Load/store unit: IDLE -> BUSY -> RESP handshake to byte-enabled data memory, stalls the core meanwhile.
// Optional LSU_MISALIGN_TRAP_EN flags misaligned/illegal accesses instead of issuing them.
module riscv_lsu (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        misalign_o,
  riscv_lsu_if.master mem
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic        is_byte;
  logic        is_half;
  logic [3:0]  be_next;
  logic [31:0] wd_next;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // size[1:0] selects the width; unknown encodings fall through to word.
  always_comb begin
    is_byte = (core_size_i[1:0] == 2'b00);
    is_half = (core_size_i[1:0] == 2'b01);
    if (is_byte) begin
      be_next = 4'b0001 << core_addr_i[1:0];
      wd_next = {4{core_wd_i[7:0]}};
    end else if (is_half) begin
      be_next = 4'b0011 << {core_addr_i[1], 1'b0};
      wd_next = {2{core_wd_i[15:0]}};
    end else begin
      be_next = 4'b1111;
      wd_next = core_wd_i;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic bad_size;
  logic bad_align;

  always_comb begin
    bad_size   = (core_size_i == 3'b011) || (core_size_i[2:1] == 2'b11) ||
                 (core_we_i && core_size_i[2]);
    bad_align  = (is_half && core_addr_i[0]) ||
                 ((core_size_i == 3'b010) && (core_addr_i[1:0] != 2'b00));
    misalign_o = (state == IDLE) && core_req_i && (bad_size || bad_align);
  end
`else
  assign misalign_o = 1'b0;
`endif

  assign core_stall_o = core_req_i && (state != RESP) && !misalign_o;

  // size_q[2] set means unsigned load (BU/HU).
  always_comb begin
    byte_sel = mem.mem_rd_i[{off_q, 3'b000} +: 8];
    half_sel = mem.mem_rd_i[{off_q[1], 4'b0000} +: 16];
    case (size_q[1:0])
      2'b00:   load_ext = {{24{~size_q[2] & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{~size_q[2] & half_sel[15]}}, half_sel};
      default: load_ext = mem.mem_rd_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      size_q         <= 3'b000;
      off_q          <= 2'b00;
      core_rd_o      <= 32'h0;
      mem.mem_req_o  <= 1'b0;
      mem.mem_we_o   <= 1'b0;
      mem.mem_be_o   <= 4'b0000;
      mem.mem_addr_o <= 32'h0;
      mem.mem_wd_o   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (core_req_i && !misalign_o) begin
            state          <= BUSY;
            size_q         <= core_size_i;
            off_q          <= core_addr_i[1:0];
            mem.mem_req_o  <= 1'b1;
            mem.mem_we_o   <= core_we_i;
            mem.mem_be_o   <= be_next;
            mem.mem_addr_o <= {core_addr_i[31:2], 2'b00};
            mem.mem_wd_o   <= wd_next;
          end
        end
        BUSY: begin
          if (mem.mem_ready_i) begin
            if (!mem.mem_we_o) begin
              core_rd_o <= load_ext;
            end
            state         <= RESP;
            mem.mem_req_o <= 1'b0;
            mem.mem_we_o  <= 1'b0;
            mem.mem_be_o  <= 4'b0000;
          end
        end
        // The request seen here belongs to the retiring instruction.
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit sitting directly downstream of the main instruction decoder in the single-cycle RISC-V core. It consumes the decoder's memory controls (`mem_req`, `mem_we`, `mem_size`) together with the ALU-computed address and the rs2 store data. It turns them into a registered, byte-enabled data-memory transaction with a ready handshake, and returns sign/zero-extended load data to the write-back mux. It stalls the core until the transaction completes.

## Interface
- No parameters.
- `clk_i` in 1: core clock; all state updates on rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `core_req_i` in 1: memory instruction present (decoder `mem_req_o`).
- `core_we_i` in 1: 1 = store, 0 = load (decoder `mem_we_o`).
- `core_size_i` in 3: funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU (decoder `mem_size_o`).
- `core_addr_i` in 32: byte address from ALU.
- `core_wd_i` in 32: store data (rs2).
- `core_rd_o` out 32: extended load data to write-back.
- `core_stall_o` out 1: hold PC/register write while 1.
- `misalign_o` out 1: one-cycle misaligned/illegal-access flag to the trap logic.
- `mem_req_o` out 1: data-memory request.
- `mem_we_o` out 1: data-memory write.
- `mem_be_o` out 4: byte enables.
- `mem_addr_o` out 32: word address, `{addr[31:2],2'b00}`.
- `mem_wd_o` out 32: lane-replicated write data.
- `mem_rd_i` in 32: read word, valid when `mem_ready_i`=1.
- `mem_ready_i` in 1: transaction complete this cycle.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE:**
  - If `core_req_i` and the access is legal: latch addr, size, we and wd into request registers, then go to BUSY.
  - If `misalign_o`: stay in IDLE.
- **BUSY:**
  - `mem_req_o`=1. `mem_we_o`, `mem_be_o`, `mem_addr_o` and `mem_wd_o` are driven from the latched registers and stay stable until ready.
  - On `mem_ready_i`=1: for a load, register the extended `mem_rd_i` into `core_rd_o`; for a store, `core_rd_o` is unchanged. Then go to RESP.
- **RESP:**
  - `core_stall_o`=0, so the core retires the instruction.
  - Unconditionally go to IDLE. `core_req_i` sampled in RESP is ignored, because it belongs to the retiring instruction.
- `core_stall_o` = `core_req_i` & (state != RESP) & ~`misalign_o`.
- Byte enables:
  - Size B/BU: `4'b0001 << addr[1:0]`.
  - Size H/HU: `4'b0011 << {addr[1],1'b0}`.
  - Size W: `4'b1111`.
- Write data:
  - B: `{4{wd[7:0]}}`.
  - H: `{2{wd[15:0]}}`.
  - W: `wd`.
- Load extraction:
  - Byte = `rd[8*addr[1:0] +: 8]`.
  - Half = `rd[16*addr[1] +: 16]`.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- Outside BUSY: `mem_req_o`=0, `mem_we_o`=0, `mem_be_o`=0. `mem_addr_o` and `mem_wd_o` hold their last latched value.

## Timing
- Reset values: state IDLE, `core_rd_o`=0, `mem_req_o`=0, `mem_we_o`=0, `mem_be_o`=0, `mem_addr_o`=0, `mem_wd_o`=0, `misalign_o`=0, `core_stall_o`=0 while `core_req_i`=0.
- Latency: with `mem_ready_i` high on the first BUSY cycle, the instruction retires on cycle 3 (IDLE, BUSY, RESP). Each extra wait cycle adds 1.
- Reset asserted in BUSY aborts the transaction: `mem_req_o` drops immediately and asynchronously, and no data is captured.
- `mem_ready_i` outside BUSY is ignored.
- Back-to-back memory instructions: the next one is latched in the IDLE cycle that follows RESP. There is no bubble beyond the FSM path.

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined:**
  - Misaligned access: H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0.
  - Illegal size: 011, 110, 111, or a store with size ≥100.
  - Either case, sampled in IDLE with `core_req_i`, asserts `misalign_o` combinationally for that cycle, issues no memory request, does not stall, and leaves the FSM in IDLE.
- **Not defined:**
  - `misalign_o` is tied to 0.
  - H ignores `addr[0]`; W ignores `addr[1:0]`.
  - Undefined sizes are treated as W.

## Test plan
- LW, addr 0x0000_0104, `mem_rd_i`=0xDEADBEEF, ready after 2 wait cycles -> `mem_be_o`=1111, `mem_addr_o`=0x104, stall high for 4 cycles, then `core_rd_o`=0xDEADBEEF with stall 0.
- LB at addr 0x...03, `mem_rd_i`=0x80123456 -> `core_rd_o`=0xFFFFFF80. LBU with the same address and data -> 0x00000080.
- SH at addr 0x...02, `core_wd_i`=0x0000ABCD -> `mem_be_o`=1100, `mem_wd_o`=0xABCDABCD, `mem_we_o`=1, `core_rd_o` unchanged.
- LW at addr 0x...01 with `LSU_MISALIGN_TRAP_EN` -> `misalign_o`=1 for one cycle, `mem_req_o` stays 0, stall 0. Without the macro -> word read at 0x...00.
- `rst_ni` low during BUSY -> `mem_req_o`=0 within the same cycle, state IDLE, `core_rd_o`=0.
- Two consecutive SW then LW with `mem_ready_i` tied 1 -> each retires in 3 cycles. The load returns the stored word.
